// File: rtl/psi_stream_threshold.sv
// psi_stream_threshold
//   Streaming N-party bitmap intersection / threshold filter. Each set is a
//   run of 1..N party bitmaps, one per accepted word. Per-element counters
//   accumulate how many parties hold each element. On the terminating word
//   the block registers a result bitmap (count >= effective threshold),
//   its popcount and a framing-error flag, and then waits for the collector.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
//   both high. The producer holds its data stable until that edge. No
//   ready depends combinationally on the matching valid.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     party word valid
//   in_ready     block accepts a word (low while a result is held)
//   in_bitmap    one party's bitmap (B bits)
//   in_last      final party word of the set
//   threshold    minimum party count; sampled with the first word of a set
//                (0 selects full intersection, i.e. all N parties)
//   out_valid    result valid
//   out_ready    collector accepts the result
//   out_bitmap   result bitmap
//   out_count    popcount of out_bitmap
//   out_err      framing error (set did not end with in_last on party N)
//   dbg_state    FSM state: 0 IDLE, 1 ACCUM, 2 DONE
module psi_stream_threshold #(
  parameter int B  = 10,
  parameter int N  = 10,
  parameter int CW = $clog2(N + 1),
  parameter int PW = $clog2(B + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [B-1:0]  in_bitmap,
  input  logic          in_last,
  input  logic [CW-1:0] threshold,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [B-1:0]  out_bitmap,
  output logic [PW-1:0] out_count,
  output logic          out_err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] N_C = CW'(N);

  state_t        state_q;
  logic [CW-1:0] cnt_q [B];
  logic [CW-1:0] cnt_d [B];
  logic [CW-1:0] pc_q;
  logic [CW-1:0] pc_d;
  logic [CW-1:0] thr_q;
  logic [CW-1:0] thr_src;
  logic [CW-1:0] eff;
  logic [B-1:0]  keep_d;
  logic [B-1:0]  out_bitmap_q;
  logic          out_valid_q;
  logic          out_err_q;
  logic          accept;
  logic          term;
  logic          err_d;
  logic [PW-1:0] pop;

  assign in_ready  = (state_q != S_DONE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_bitmap = out_bitmap_q;
  assign out_err   = out_err_q;
  assign out_count = pop;
  assign dbg_state = state_q;

  // On the first word of a set thr_q is not loaded yet, so the threshold
  // port itself supplies the comparison level (matters for 1-word sets).
  assign thr_src = (state_q == S_IDLE) ? threshold : thr_q;
  assign eff     = (thr_src == '0) ? N_C : thr_src;
  assign pc_d    = pc_q + CW'(1);
  assign term    = in_last || (pc_d == N_C);
  assign err_d   = !((pc_d == N_C) && in_last);

  // Counters are zero in IDLE, so the same add serves the first word.
  // pc never passes N, so no counter can exceed N or wrap.
  always_comb begin
    for (int i = 0; i < B; i++) begin
      cnt_d[i]  = cnt_q[i] + CW'(in_bitmap[i]);
      keep_d[i] = (cnt_d[i] >= eff);
    end
  end

  // Popcount taken from the registered result bitmap.
  always_comb begin
    pop = '0;
    for (int i = 0; i < B; i++) begin
      pop = pop + PW'(out_bitmap_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      thr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_bitmap_q <= '0;
      out_err_q    <= 1'b0;
      for (int i = 0; i < B; i++) cnt_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            for (int i = 0; i < B; i++) cnt_q[i] <= cnt_d[i];
            pc_q <= pc_d;
            if (state_q == S_IDLE) thr_q <= threshold;
            if (term) begin
              state_q      <= S_DONE;
              out_valid_q  <= 1'b1;
              out_bitmap_q <= keep_d;
              out_err_q    <= err_d;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            for (int i = 0; i < B; i++) cnt_q[i] <= '0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psi_stream_threshold.sv
module tb_psi_stream_threshold;

  localparam int B  = 10;
  localparam int N  = 10;
  localparam int CW = 4;
  localparam int PW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [B-1:0]  in_bitmap = '0;
  logic          in_last = 1'b0;
  logic [CW-1:0] threshold = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [B-1:0]  out_bitmap;
  logic [PW-1:0] out_count;
  logic          out_err;
  logic [1:0]    dbg_state;

  psi_stream_threshold #(.B(B), .N(N), .CW(CW), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bitmap(in_bitmap),
    .in_last(in_last), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready), .out_bitmap(out_bitmap),
    .out_count(out_count), .out_err(out_err), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // words of the set currently being driven
  logic [B-1:0] words_q[$];

  // expected result
  logic [B-1:0]  exp_bm;
  logic [PW-1:0] exp_cnt;
  logic          exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: count holders per element over the whole set.
  task automatic model(input int thr, input bit last_flag);
    int eff;
    int c;
    int pop;
    eff = (thr == 0) ? N : thr;
    pop = 0;
    for (int b = 0; b < B; b++) begin
      c = 0;
      foreach (words_q[k]) c += int'(words_q[k][b]);
      exp_bm[b] = (c >= eff);
      if (c >= eff) pop++;
    end
    exp_cnt = PW'(pop);
    exp_err = !(words_q.size() == N && last_flag);
  endtask

  // Drive one word starting at a negedge; returns at the negedge after the
  // accepting posedge with in_valid dropped.
  task automatic send_word(input logic [B-1:0] w, input bit last, input logic [CW-1:0] thr);
    int waited;
    waited = 0;
    in_valid  = 1'b1;
    in_bitmap = w;
    in_last   = last;
    threshold = thr;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    threshold = CW'($urandom);  // must be ignored mid-set
  endtask

  task automatic drive_set(input int thr, input bit last_flag, input int gap_max);
    for (int i = 0; i < words_q.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_word(words_q[i], last_flag && (i == words_q.size() - 1),
                (i == 0) ? CW'(thr) : CW'($urandom));
      if (i != words_q.size() - 1) chk("no_early_valid", 32'(out_valid), 32'd0);
    end
  endtask

  // Called at the negedge right after the terminating accept.
  task automatic expect_set(input string tag, input int thr, input bit last_flag, input int stall);
    model(thr, last_flag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_bitmap"}, 32'(out_bitmap), 32'(exp_bm));
    chk({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold"}, {20'd0, out_valid, out_err, out_bitmap},
          {20'd0, 1'b1, exp_err, exp_bm});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_released"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic fill(input int n, input logic [B-1:0] w);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back(w);
  endtask

  initial begin
    int k;
    int thr;
    bit lf;
    logic [B-1:0] base;

    // reset values
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_bitmap", 32'(out_bitmap), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // full intersection, one party missing two elements
    fill(10, 10'h3FF);
    words_q[2] = 10'h3F5;
    drive_set(0, 1'b1, 0);
    chk("t1_bm_direct", 32'(out_bitmap), 32'h3F5);
    chk("t1_cnt_direct", 32'(out_count), 32'd8);
    expect_set("t1", 0, 1'b1, 0);

    // threshold 3
    words_q = '{10'h001, 10'h001, 10'h001, 10'h002, 10'h002,
                10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    drive_set(3, 1'b1, 1);
    chk("t2_bm_direct", 32'(out_bitmap), 32'h001);
    expect_set("t2", 3, 1'b1, 0);

    // early last on word 4
    fill(4, 10'h3FF);
    drive_set(0, 1'b1, 0);
    chk("t3_bm_direct", 32'(out_bitmap), 32'h000);
    chk("t3_err_direct", 32'(out_err), 32'd1);
    expect_set("t3", 0, 1'b1, 0);
    fill(10, 10'h155);
    drive_set(0, 1'b1, 2);
    chk("t3b_cnt_direct", 32'(out_count), 32'd5);
    expect_set("t3b", 0, 1'b1, 0);

    // single-word set with last, threshold 1
    fill(1, 10'h2A3);
    drive_set(1, 1'b1, 0);
    expect_set("t_one", 1, 1'b1, 1);

    // no in_last: terminated by party count
    fill(10, 10'h0FF);
    drive_set(0, 1'b0, 0);
    expect_set("t4a", 0, 1'b0, 0);
    fill(10, 10'h3FF);
    drive_set(11, 1'b0, 0);
    chk("t4b_bm_direct", 32'(out_bitmap), 32'h000);
    chk("t4b_err_direct", 32'(out_err), 32'd1);
    expect_set("t4b", 11, 1'b0, 0);

    // backpressure with a pending word that becomes party 1 of next set
    fill(10, 10'h033);
    drive_set(0, 1'b1, 0);
    in_valid  = 1'b1;
    in_bitmap = 10'h3FF;
    in_last   = 1'b0;
    threshold = '0;
    expect_set("t5", 0, 1'b1, 5);
    fill(10, 10'h3FF);
    words_q[4] = 10'h1FE;
    send_word(words_q[0], 1'b0, '0);
    for (int i = 1; i < 10; i++) send_word(words_q[i], i == 9, CW'($urandom));
    expect_set("t5b", 0, 1'b1, 0);

    // reset in the middle of a set
    fill(6, 10'h3FF);
    drive_set(0, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill(10, 10'h0F0);
    drive_set(0, 1'b1, 0);
    chk("t6_cnt_direct", 32'(out_count), 32'd4);
    expect_set("t6", 0, 1'b1, 0);

    // reset while holding a result
    fill(3, 10'h00F);
    drive_set(2, 1'b1, 0);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // randomized sets
    for (int r = 0; r < 30; r++) begin
      k    = $urandom_range(1, N);
      thr  = $urandom_range(0, 12);
      lf   = (k < N) ? 1'b1 : 1'($urandom_range(0, 1));
      base = B'($urandom);
      words_q.delete();
      for (int i = 0; i < k; i++) words_q.push_back(base | (B'($urandom) & B'($urandom)));
      drive_set(thr, lf, 2);
      expect_set("rand", thr, lf, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psi_stream_threshold.md
# psi_stream_threshold

Streaming, parametrised successor to the flat N-party bitmap-intersection AND tree in the PSI netlists. Party bitmaps arrive one word per cycle over a valid/ready stream. Per-bit occurrence counters accumulate across parties. When a set completes, the block emits a registered result:
- Full intersection mode: an element is kept when all N parties hold it.
- Threshold mode: an element is kept when at least T parties hold it.

The result carries its popcount and a framing-error flag. The block sits between the party-input deserialiser and the result collector.

## Interface
Parameters:
- B, 10, bitmap width (elements per party)
- N, 10, parties per set (N ≥ 2)
- CW, $clog2(N+1), counter / threshold width
- PW, $clog2(B+1), popcount width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts a word
- in_bitmap  in  B  one party's bitmap
- in_last  in  1  marks the final party word of a set
- threshold  in  CW  minimum party count per element; sampled with the first word of each set
- out_valid  out  1  result valid
- out_ready  in  1  collector accepts result
- out_bitmap  out  B  result bitmap
- out_count  out  PW  popcount of out_bitmap
- out_err  out  1  framing error for this set

## Operation
- Accept: a word is accepted on any clock edge where in_valid && in_ready.
- States:
  - IDLE: no words held.
  - ACCUM: 1 to N-1 words held.
  - DONE: result held.
- in_ready = (state != DONE).
- IDLE → ACCUM on the first accept. On this accept:
  - thr_q is latched from threshold.
  - party counter pc is set to 1.
  - cnt[i] is set to in_bitmap[i].
- ACCUM, on each accept:
  - cnt[i] += in_bitmap[i].
  - pc += 1.
- Set termination: the first accept with in_last=1 or pc reaching N. This includes a first word with in_last=1, which goes IDLE → DONE directly. On the terminating accept, the following are registered and the state moves to DONE:
  - eff = (thr_q == 0) ? N : thr_q. Zero selects full-intersection mode.
  - out_bitmap[i] = (cnt_final[i] ≥ eff). cnt_final includes the terminating word.
  - out_count = popcount(out_bitmap).
  - out_err = (final pc != N) || (final pc == N && !in_last).
- An in_last arriving with pc < N gives an early termination: the result is computed over the words received so far, with err=1.
- Threshold above N is legal and yields an all-zero bitmap with count 0.
- DONE:
  - out_valid=1. Outputs are held stable until out_valid && out_ready.
  - On that handshake: next state IDLE, cnt and pc cleared, out_valid=0.
  - out_bitmap, out_count and out_err keep their last values but are don't-care while out_valid=0.
- Width rules:
  - cnt[i] never exceeds N and never wraps.
  - Comparisons are unsigned at CW bits.
  - The popcount is computed from the registered comparison result.

## Timing
- Reset values:
  - state IDLE, in_ready=1.
  - out_valid=0, out_bitmap=0, out_count=0, out_err=0.
  - all cnt=0, pc=0, thr_q=0.
- Reset asserted mid-set or in DONE discards all state immediately, with no output.
- Latency: out_valid rises at the same edge that accepts the terminating word (result registered). It is visible in the following cycle.
- in_ready is low for the whole time out_valid is high. in_valid asserted then is ignored, and the data is not consumed.
- If out_ready is high the cycle out_valid appears, the handshake completes at the next edge. in_ready returns high one cycle later.
- Minimum cost: N + 1 cycles per set. There is no overlap of output and next-set input.
- in_valid gaps mid-set are allowed and do not change state.
- threshold is ignored except on the first accepted word of a set.

## Test plan
- B=10, N=10, threshold=0; 10 words of 0x3FF, except word 3 = 0x3F5; in_last on word 10 → out_bitmap=0x3F5, out_count=8, out_err=0, out_valid the cycle after the 10th accept.
- threshold=3; words 0x001 ×3 and 0x002 ×2, then 0x000 ×5 with last on word 10 → out_bitmap=0x001, out_count=1, out_err=0.
- in_last on word 4, all words 0x3FF, threshold=0 → out_bitmap=0x000 (4 < 10), out_err=1. Next set starts clean: 10 × 0x155 gives 0x155, count 5.
- 10 words without in_last → result produced after word 10 with out_err=1. With threshold=11 the bitmap is 0x000, count 0.
- Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with word 0x3FF → in_ready=0 and outputs stable throughout. After the handshake, the pending word is accepted as party 1 of the next set.
- Assert rst after word 6 of a set, then send a full set of 10 × 0x0F0 → out_bitmap=0x0F0, count 4, err=0. Nothing from the aborted set is output.
